// File: rtl/seg_scroll_controller.sv
// seg_scroll_controller
//   Scrolls an ASCII message buffer across two 7-segment digits, one
//   character position per STEP_CYCLES clocks. The two character outputs
//   feed the character-to-segment decoder instances.
//
//   Optional feature macro: SCROLL_WRAP_EN
//     defined   : index wraps modulo len, scrolling never finishes on its own
//     undefined : scrolling ends after the last position with an o_Done pulse
//
//   Ports:
//     i_Clk, i_Reset          clock, asynchronous active-high reset
//     i_Wr_En/Addr/Data       buffer write port (IDLE only)
//     i_Length, i_Start       message length and start strobe (IDLE only)
//     i_Pause, i_Stop         level pause, abort to IDLE
//     o_Char_Left/Right       ASCII for digit 1 / digit 2
//     o_Busy                  high in RUN or PAUSE
//     o_Step, o_Done          one-cycle advance / completion pulses
module seg_scroll_controller #(
  parameter int unsigned STEP_CYCLES = 12500000,
  parameter int unsigned MAX_CHARS   = 16,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Wr_En,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  logic [7:0]        i_Wr_Data,
  input  logic [ADDR_W:0]   i_Length,
  input  logic              i_Start,
  input  logic              i_Pause,
  input  logic              i_Stop,
  output logic [7:0]        o_Char_Left,
  output logic [7:0]        o_Char_Right,
  output logic              o_Busy,
  output logic              o_Step,
  output logic              o_Done
);

  localparam int unsigned CNT_W = $clog2(STEP_CYCLES);
  localparam logic [7:0]  SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pos, pos_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W:0]   len, len_n;
  logic [7:0]        left_n, right_n;
  logic              step_n, done_n;
  logic [7:0]        msg_buf [MAX_CHARS];

  logic              start_ok;
  logic              wr_ok;
  logic [ADDR_W:0]   pos_ext;
  logic [ADDR_W:0]   nxt;
  logic              last_pos;
  logic [7:0]        win_left, win_right;

  assign start_ok = i_Start && (i_Length != '0) &&
                    (i_Length <= (ADDR_W+1)'(MAX_CHARS));
  assign wr_ok    = i_Wr_En && (state == IDLE) &&
                    ({1'b0, i_Wr_Addr} < (ADDR_W+1)'(MAX_CHARS));
  assign pos_ext  = {1'b0, pos};
  assign nxt      = pos_ext + (ADDR_W+1)'(1);
  assign last_pos = (nxt == len);
  assign win_left = msg_buf[pos];

  always_comb begin
    if (nxt < len) begin
      win_right = msg_buf[nxt[ADDR_W-1:0]];
    end else begin
`ifdef SCROLL_WRAP_EN
      win_right = msg_buf[0];
`else
      win_right = SPACE;
`endif
    end
  end

  // Writes are only taken in IDLE, so the buffer is stable while scrolling.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < MAX_CHARS; i++) begin
        msg_buf[i] <= SPACE;
      end
    end else if (wr_ok) begin
      msg_buf[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= IDLE;
      pos          <= '0;
      cnt          <= '0;
      len          <= '0;
      o_Char_Left  <= SPACE;
      o_Char_Right <= SPACE;
      o_Busy       <= 1'b0;
      o_Step       <= 1'b0;
      o_Done       <= 1'b0;
    end else begin
      state        <= state_n;
      pos          <= pos_n;
      cnt          <= cnt_n;
      len          <= len_n;
      o_Char_Left  <= left_n;
      o_Char_Right <= right_n;
      o_Busy       <= (state_n != IDLE);
      o_Step       <= step_n;
      o_Done       <= done_n;
    end
  end

  // Character outputs register the window of the current pos, so they
  // follow a pos update by one edge; leaving RUN/PAUSE blanks them at once.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    cnt_n   = cnt;
    len_n   = len;
    step_n  = 1'b0;
    done_n  = 1'b0;
    left_n  = SPACE;
    right_n = SPACE;

    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = RUN;
          pos_n   = '0;
          cnt_n   = '0;
          len_n   = i_Length;
        end
      end
      RUN, PAUSE: begin
        if (i_Stop) begin
          state_n = IDLE;
        end else begin
          left_n  = win_left;
          right_n = win_right;
          if (i_Pause) begin
            state_n = PAUSE;
          end else begin
            state_n = RUN;
            if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
              cnt_n = '0;
              if (last_pos) begin
`ifdef SCROLL_WRAP_EN
                pos_n  = '0;
                step_n = 1'b1;
`else
                state_n = IDLE;
                done_n  = 1'b1;
                left_n  = SPACE;
                right_n = SPACE;
`endif
              end else begin
                pos_n  = pos + ADDR_W'(1);
                step_n = 1'b1;
              end
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seg_scroll_controller.sv
// tb_seg_scroll_controller
//   Directed bench for seg_scroll_controller with STEP_CYCLES = 4.
//   Cycle k counts clock edges after the edge that accepts i_Start.
module tb_seg_scroll_controller;

  localparam int unsigned STEP = 4;
  localparam int unsigned AW   = 4;

  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic          i_Wr_En;
  logic [AW-1:0] i_Wr_Addr;
  logic [7:0]    i_Wr_Data;
  logic [AW:0]   i_Length;
  logic          i_Start;
  logic          i_Pause;
  logic          i_Stop;
  logic [7:0]    o_Char_Left;
  logic [7:0]    o_Char_Right;
  logic          o_Busy;
  logic          o_Step;
  logic          o_Done;

  int n_chk  = 0;
  int n_pass = 0;

  seg_scroll_controller #(
    .STEP_CYCLES (STEP),
    .MAX_CHARS   (16),
    .ADDR_W      (AW)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Wr_En      (i_Wr_En),
    .i_Wr_Addr    (i_Wr_Addr),
    .i_Wr_Data    (i_Wr_Data),
    .i_Length     (i_Length),
    .i_Start      (i_Start),
    .i_Pause      (i_Pause),
    .i_Stop       (i_Stop),
    .o_Char_Left  (o_Char_Left),
    .o_Char_Right (o_Char_Right),
    .o_Busy       (o_Busy),
    .o_Step       (o_Step),
    .o_Done       (o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check_win(input string tag, input string w);
    chk({tag, "_left"},  {24'd0, o_Char_Left},  {24'd0, w[0]});
    chk({tag, "_right"}, {24'd0, o_Char_Right}, {24'd0, w[1]});
  endtask

  task automatic write_char(input int a, input byte d);
    i_Wr_En   = 1'b1;
    i_Wr_Addr = AW'(a);
    i_Wr_Data = d;
    tick();
    i_Wr_En   = 1'b0;
  endtask

  task automatic write_hello();
    write_char(0, "H");
    write_char(1, "E");
    write_char(2, "L");
    write_char(3, "L");
    write_char(4, "O");
  endtask

  task automatic start_len(input int n);
    i_Length = (AW+1)'(n);
    i_Start  = 1'b1;
    tick();
    i_Start  = 1'b0;
  endtask

  string win5 [5] = '{"HE", "EL", "LL", "LO", "O "};
  string wab  [2] = '{"AB", "BA"};

  initial begin
    i_Reset = 1'b1; i_Wr_En = 1'b0; i_Wr_Addr = '0; i_Wr_Data = '0;
    i_Length = '0; i_Start = 1'b0; i_Pause = 1'b0; i_Stop = 1'b0;
    tick(); tick();
    check_win("rst", "  ");
    chk("rst_busy", {31'd0, o_Busy}, 32'd0);
    chk("rst_step", {31'd0, o_Step}, 32'd0);
    chk("rst_done", {31'd0, o_Done}, 32'd0);
    i_Reset = 1'b0;
    tick();

`ifndef SCROLL_WRAP_EN
    // 1: HELLO full scroll
    write_hello();
    start_len(5);
    chk("t1_busy0", {31'd0, o_Busy}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k < 20) check_win("t1", win5[(k-1)/4]);
      else        check_win("t1_end", "  ");
      chk("t1_step", {31'd0, o_Step}, {31'd0, (k % 4 == 0) && (k < 20)});
      chk("t1_done", {31'd0, o_Done}, {31'd0, k == 20});
      chk("t1_busy", {31'd0, o_Busy}, {31'd0, k < 20});
    end

    // 2: asynchronous reset mid-run at "LL", buffer cleared
    start_len(5);
    for (int k = 1; k <= 10; k++) tick();
    check_win("t2_pre", "LL");
    i_Reset = 1'b1;
    #1;
    check_win("t2_async", "  ");
    chk("t2_busy", {31'd0, o_Busy}, 32'd0);
    tick();
    i_Reset = 1'b0;
    tick();
    start_len(5);
    tick();
    check_win("t2_clr", "  ");
    chk("t2_busy_run", {31'd0, o_Busy}, 32'd1);
    i_Stop = 1'b1;
    tick();
    i_Stop = 1'b0;
    chk("t2_stop", {31'd0, o_Busy}, 32'd0);

    // 3: pause held 10 edges during "EL"
    write_hello();
    start_len(5);
    for (int k = 1; k <= 30; k++) begin
      int e;
      tick();
      e = (k <= 5) ? k : ((k <= 15) ? 5 : k - 10);
      if (k < 30) check_win("t3", win5[(e-1)/4]);
      else        check_win("t3_end", "  ");
      chk("t3_step", {31'd0, o_Step}, {31'd0, (e % 4 == 0) && (e < 20)});
      chk("t3_done", {31'd0, o_Done}, {31'd0, k == 30});
      i_Pause = (k >= 5) && (k < 15);
    end

    // 4: stop with pause on a step boundary
    start_len(5);
    for (int k = 1; k <= 3; k++) tick();
    i_Pause = 1'b1;
    i_Stop  = 1'b1;
    tick();
    i_Pause = 1'b0;
    i_Stop  = 1'b0;
    check_win("t4", "  ");
    chk("t4_busy", {31'd0, o_Busy}, 32'd0);
    chk("t4_step", {31'd0, o_Step}, 32'd0);
    chk("t4_done", {31'd0, o_Done}, 32'd0);
    tick();
    chk("t4_idle", {31'd0, o_Busy}, 32'd0);

    // 5: illegal lengths, write during run, write+start together, len 1
    start_len(0);
    tick();
    chk("t5_len0", {31'd0, o_Busy}, 32'd0);
    start_len(17);
    tick();
    chk("t5_len17", {31'd0, o_Busy}, 32'd0);
    start_len(5);
    tick();
    write_char(3, "X");
    i_Stop = 1'b1;
    tick();
    i_Stop = 1'b0;
    i_Wr_En = 1'b1; i_Wr_Addr = AW'(0); i_Wr_Data = "Y";
    start_len(5);
    i_Wr_En = 1'b0;
    tick();
    check_win("t5_wrstart", "YE");
    for (int k = 2; k <= 13; k++) tick();
    check_win("t5_keep", "LO");
    i_Stop = 1'b1;
    tick();
    i_Stop = 1'b0;
    start_len(1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) check_win("t5_len1", "Y ");
      chk("t5_len1_done", {31'd0, o_Done}, {31'd0, k == 4});
      chk("t5_len1_step", {31'd0, o_Step}, 32'd0);
    end
`else
    // 6: wrap mode, "AB" repeating, never done
    write_char(0, "A");
    write_char(1, "B");
    start_len(2);
    for (int k = 1; k <= 100; k++) begin
      tick();
      check_win("t6", wab[((k-1)/4) % 2]);
      chk("t6_step", {31'd0, o_Step}, {31'd0, k % 4 == 0});
      chk("t6_done", {31'd0, o_Done}, 32'd0);
    end
    i_Stop = 1'b1;
    tick();
    i_Stop = 1'b0;
    check_win("t6_stop", "  ");
    chk("t6_busy", {31'd0, o_Busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
